// File: rtl/board_sync_pkg.sv
// board_sync_pkg: state codes and default widths shared by the board synchroniser controller
package board_sync_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIG  = 3'd1,
        ST_ARM     = 3'd2,
        ST_MEASURE = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;
    localparam int DEF_CNT_WIDTH    = 2;
    localparam int DEF_OFS_WIDTH    = 8;
    localparam int DEF_LOCK_PERIODS = 4;
    localparam int DEF_TMO_WIDTH    = 16;
endpackage

// File: rtl/sync_offset_meter.sv
// sync_offset_meter: measures cycles from a sync_int rise to the next sync_ext rise
module sync_offset_meter #(
    parameter int OFS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync_int,
    input  logic                 sync_ext,
    output logic                 int_rise,
    output logic                 valid,
    output logic                 miss,
    output logic [OFS_WIDTH-1:0] sample
);
    logic                 int_q, ext_q, act_q, act_d, ext_rise, sat;
    logic [OFS_WIDTH-1:0] cnt_q, cnt_d;
    // edge strobes and the running count; a simultaneous int/ext rise yields a zero sample
    always_comb begin
        int_rise = sync_int & ~int_q;
        ext_rise = sync_ext & ~ext_q;
        sat      = &cnt_q;
        sample   = int_rise ? '0 : cnt_q;
        valid    = en & ext_rise & (int_rise | act_q);
        miss     = en & act_q & ~ext_rise & (int_rise | sat);
        act_d    = en & (int_rise ? ~ext_rise : act_q & ~ext_rise & ~sat);
        cnt_d    = ~en ? '0 : int_rise ? OFS_WIDTH'(1) : (act_q & ~sat) ? cnt_q + 1'b1 : cnt_q;
    end
    // input history for edge detection plus the counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= 1'b0;
            ext_q <= 1'b0;
            act_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            int_q <= sync_int;
            ext_q <= sync_ext;
            act_q <= act_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/board_sync_ctrl.sv
// board_sync_ctrl: configures the n-high-in-m synchroniser and supervises loop-back lock
// Optional min/max offset tracking is enabled by defining BOARD_SYNC_CTRL_MINMAX_EN.
module board_sync_ctrl
    import board_sync_pkg::*;
#(
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int OFS_WIDTH    = DEF_OFS_WIDTH,
    parameter int LOCK_PERIODS = DEF_LOCK_PERIODS,
    parameter int TMO_WIDTH    = DEF_TMO_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 trig_in,
    input  logic [CNT_WIDTH-1:0] cnt_n_cfg,
    input  logic [CNT_WIDTH-1:0] cnt_m_cfg,
    input  logic                 sync_int,
    input  logic                 sync_ext,
    output logic                 synch_en,
    output logic                 toggle_en,
    output logic [CNT_WIDTH-1:0] cnt_n,
    output logic [CNT_WIDTH-1:0] cnt_m,
    output logic [OFS_WIDTH-1:0] offset,
    output logic                 locked,
    output logic                 lock_lost,
    output logic                 fault,
    output logic [2:0]           state
`ifdef BOARD_SYNC_CTRL_MINMAX_EN
    ,
    output logic [OFS_WIDTH-1:0] ofs_min,
    output logic [OFS_WIDTH-1:0] ofs_max
`endif
);
    localparam logic [3:0] MATCH_LAST = 4'(LOCK_PERIODS - 1);
    state_e                 state_q, state_d;
    logic                   synch_en_q, synch_en_d, toggle_en_q, toggle_en_d;
    logic                   locked_q, locked_d, lock_lost_q, lock_lost_d, fault_q, fault_d;
    logic [CNT_WIDTH-1:0]   cnt_n_q, cnt_n_d, cnt_m_q, cnt_m_d;
    logic [OFS_WIDTH-1:0]   offset_q, offset_d, prev_q, prev_d, sample;
    logic [3:0]             match_q, match_d;
    logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
    logic                   int_rise, valid, miss, meas, bad;
    assign meas = state_q inside {ST_ARM, ST_MEASURE, ST_LOCKED};
    sync_offset_meter #(.OFS_WIDTH(OFS_WIDTH)) u_meter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (meas),
        .sync_int (sync_int),
        .sync_ext (sync_ext),
        .int_rise (int_rise),
        .valid    (valid),
        .miss     (miss),
        .sample   (sample)
    );
    // next-state, match/timeout bookkeeping and registered outputs derived from the next state
    always_comb begin
        bad         = meas & (miss | (valid & (sample != prev_q)));
        match_d     = (~meas | bad) ? '0 : (valid & (match_q != MATCH_LAST)) ? match_q + 4'd1 : match_q;
        prev_d      = (meas & valid) ? sample : prev_q;
        offset_d    = (meas & valid) ? sample : offset_q;
        tmo_d       = (state_q inside {ST_ARM, ST_MEASURE}) ? ((&tmo_q) ? tmo_q : tmo_q + 1'b1) : '0;
        cnt_n_d     = (state_q == ST_CONFIG) ? cnt_n_cfg : cnt_n_q;
        cnt_m_d     = (state_q == ST_CONFIG) ? cnt_m_cfg : cnt_m_q;
        state_d     = state_q;
        case (state_q)
            ST_IDLE:    state_d = arm ? ST_CONFIG : ST_IDLE;
            ST_CONFIG:  state_d = (cnt_n_cfg >= cnt_m_cfg) ? ST_FAULT : ST_ARM;
            ST_ARM:     state_d = int_rise ? ST_MEASURE : ST_ARM;
            ST_MEASURE: state_d = (valid & (match_d == MATCH_LAST)) ? ST_LOCKED : (&tmo_q) ? ST_FAULT : ST_MEASURE;
            ST_LOCKED:  state_d = bad ? ST_MEASURE : ST_LOCKED;
            default:    state_d = state_q;
        endcase
        if (disarm) state_d = ST_IDLE;
        synch_en_d  = state_d inside {ST_ARM, ST_MEASURE, ST_LOCKED};
        locked_d    = state_d == ST_LOCKED;
        fault_d     = state_d == ST_FAULT;
        lock_lost_d = (state_q == ST_LOCKED) & (state_d == ST_MEASURE);
        toggle_en_d = trig_in & (state_q != ST_IDLE);
    end
    // controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            synch_en_q  <= 1'b0;
            toggle_en_q <= 1'b0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            fault_q     <= 1'b0;
            cnt_n_q     <= '0;
            cnt_m_q     <= '0;
            offset_q    <= '0;
            prev_q      <= '0;
            match_q     <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            synch_en_q  <= synch_en_d;
            toggle_en_q <= toggle_en_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            fault_q     <= fault_d;
            cnt_n_q     <= cnt_n_d;
            cnt_m_q     <= cnt_m_d;
            offset_q    <= offset_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            tmo_q       <= tmo_d;
        end
    end
    assign state     = state_q;
    assign synch_en  = synch_en_q;
    assign toggle_en = toggle_en_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
    assign fault     = fault_q;
    assign cnt_n     = cnt_n_q;
    assign cnt_m     = cnt_m_q;
    assign offset    = offset_q;
`ifdef BOARD_SYNC_CTRL_MINMAX_EN
    logic [OFS_WIDTH-1:0] min_q, min_d, max_q, max_d, min_b, max_b;
    // extremes restart when measurement begins, then track every valid sample
    always_comb begin
        min_b = (state_q == ST_ARM && int_rise) ? '1 : min_q;
        max_b = (state_q == ST_ARM && int_rise) ? '0 : max_q;
        min_d = (meas & valid & (sample < min_b)) ? sample : min_b;
        max_d = (meas & valid & (sample > max_b)) ? sample : max_b;
    end
    // min/max readback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end
    assign ofs_min = min_q;
    assign ofs_max = max_q;
`endif
endmodule
